// File: rtl/gpio_ctrl_pkg.sv
// Shared GPIO pad-control definitions: configuration word layout, drive-mode
// encodings and reset configuration. Used by gpio_ctrl_shift and the housekeeping serializer.
package gpio_ctrl_pkg;

   localparam int unsigned PAD_CTRL_BITS = 13;

   localparam int unsigned GPIO_MGMT_ENA    = 0;
   localparam int unsigned GPIO_OUTENB      = 1;
   localparam int unsigned GPIO_HOLDOVER    = 2;
   localparam int unsigned GPIO_INP_DIS     = 3;
   localparam int unsigned GPIO_IB_MODE_SEL = 4;
   localparam int unsigned GPIO_ANA_EN      = 5;
   localparam int unsigned GPIO_ANA_SEL     = 6;
   localparam int unsigned GPIO_ANA_POL     = 7;
   localparam int unsigned GPIO_SLOW_SEL    = 8;
   localparam int unsigned GPIO_VTRIP_SEL   = 9;
   localparam int unsigned GPIO_DM_LSB      = 10;
   localparam int unsigned GPIO_DM_MSB      = 12;

   typedef enum logic [2:0] {
      GPIO_DM_ANALOG     = 3'b000,
      GPIO_DM_INPUT      = 3'b001,
      GPIO_DM_INPUT_PULL = 3'b010,
      GPIO_DM_OUT_OD     = 3'b011,
      GPIO_DM_OUT_STRONG = 3'b110
   } gpio_dm_e;

   // mgmt_ena=1, outenb=1, dm=output strong
   localparam logic [PAD_CTRL_BITS-1:0] CFG_DEFAULT = 13'h1803;

endpackage

// File: rtl/gpio_in_sync.sv
// Two-flop synchronizer for the raw pad input; only present when
// GPIO_CTRL_INPUT_SYNC_EN is defined.
module gpio_in_sync (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/gpio_ctrl_shift.sv
// Per-pad GPIO control stage: serial configuration shift/load and pad data steering.
// Optional input synchronizer enabled by defining GPIO_CTRL_INPUT_SYNC_EN.
module gpio_ctrl_shift #(
   parameter int unsigned PAD_CTRL_BITS = gpio_ctrl_pkg::PAD_CTRL_BITS,
   parameter logic [PAD_CTRL_BITS-1:0] CFG_DEFAULT = gpio_ctrl_pkg::CFG_DEFAULT
) (
   input  logic       wb_clk_i,
   input  logic       wb_rst_i,
   input  logic       serial_data_in,
   input  logic       serial_shift,
   input  logic       serial_load,
   output logic       serial_data_out,
   output logic       cfg_update,
   input  logic       mgmt_gpio_out,
   input  logic       mgmt_gpio_oeb,
   output logic       mgmt_gpio_in,
   input  logic       user_gpio_out,
   input  logic       user_gpio_oeb,
   output logic       user_gpio_in,
   input  logic       pad_gpio_in,
   output logic       pad_gpio_out,
   output logic       pad_gpio_outenb,
   output logic       pad_gpio_inenb,
   output logic       pad_gpio_holdover,
   output logic       pad_gpio_ib_mode_sel,
   output logic       pad_gpio_vtrip_sel,
   output logic       pad_gpio_slow_sel,
   output logic       pad_gpio_ana_en,
   output logic       pad_gpio_ana_sel,
   output logic       pad_gpio_ana_pol,
   output logic [2:0] pad_gpio_dm
);
   import gpio_ctrl_pkg::*;

   logic [PAD_CTRL_BITS-1:0] shift_q, shift_d;
   logic [PAD_CTRL_BITS-1:0] cfg_q, cfg_d;
   logic                     cfg_update_q, cfg_update_d;
   logic                     pad_in_s;
   logic                     pad_in_gated;

   // Load samples the pre-shift register, so shift and load may coincide.
   always_comb begin
      shift_d      = shift_q;
      cfg_d        = cfg_q;
      cfg_update_d = serial_load;
      if (serial_shift) shift_d = {shift_q[PAD_CTRL_BITS-2:0], serial_data_in};
      if (serial_load)  cfg_d   = shift_q;
   end

   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         shift_q      <= '0;
         cfg_q        <= CFG_DEFAULT;
         cfg_update_q <= 1'b0;
      end else begin
         shift_q      <= shift_d;
         cfg_q        <= cfg_d;
         cfg_update_q <= cfg_update_d;
      end
   end

   assign serial_data_out = shift_q[PAD_CTRL_BITS-1];
   assign cfg_update      = cfg_update_q;

`ifdef GPIO_CTRL_INPUT_SYNC_EN
   gpio_in_sync u_in_sync (
      .clk (wb_clk_i),
      .rst (wb_rst_i),
      .d   (pad_gpio_in),
      .q   (pad_in_s)
   );
`else
   assign pad_in_s = pad_gpio_in;
`endif

   always_comb begin
      pad_in_gated = pad_in_s & ~cfg_q[GPIO_INP_DIS];
      mgmt_gpio_in = '0;
      user_gpio_in = '0;
      if (cfg_q[GPIO_MGMT_ENA]) begin
         pad_gpio_out    = mgmt_gpio_out;
         // A pad configured as input cannot be driven by management.
         pad_gpio_outenb = mgmt_gpio_oeb | cfg_q[GPIO_OUTENB];
         mgmt_gpio_in    = pad_in_gated;
      end else begin
         pad_gpio_out    = user_gpio_out;
         pad_gpio_outenb = user_gpio_oeb;
         user_gpio_in    = pad_in_gated;
      end
   end

   always_comb begin
      pad_gpio_inenb       = cfg_q[GPIO_INP_DIS];
      pad_gpio_holdover    = cfg_q[GPIO_HOLDOVER];
      pad_gpio_ib_mode_sel = cfg_q[GPIO_IB_MODE_SEL];
      pad_gpio_vtrip_sel   = cfg_q[GPIO_VTRIP_SEL];
      pad_gpio_slow_sel    = cfg_q[GPIO_SLOW_SEL];
      pad_gpio_ana_en      = cfg_q[GPIO_ANA_EN];
      pad_gpio_ana_sel     = cfg_q[GPIO_ANA_SEL];
      pad_gpio_ana_pol     = cfg_q[GPIO_ANA_POL];
      pad_gpio_dm          = cfg_q[GPIO_DM_MSB:GPIO_DM_LSB];
   end

endmodule

// File: tb/tb_gpio_ctrl_shift.sv
// Scoreboard bench for gpio_ctrl_shift: two chained pads, directed vectors.
// Honours GPIO_CTRL_INPUT_SYNC_EN for the pad-input latency checks.
module tb_gpio_ctrl_shift;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, sdi, shift, load;
   logic mgmt_out, mgmt_oeb, user_out, user_oeb, pad_in;

   logic sdo1, upd1, m_in1, u_in1, p_out1, p_oeb1, inenb1, hold1, ib1, vt1, sl1, ae1, as1, ap1;
   logic [2:0] dm1;
   logic sdo2, upd2, m_in2, u_in2, p_out2, p_oeb2, inenb2, hold2, ib2, vt2, sl2, ae2, as2, ap2;
   logic [2:0] dm2;

   gpio_ctrl_shift dut (
      .wb_clk_i(clk), .wb_rst_i(rst), .serial_data_in(sdi), .serial_shift(shift),
      .serial_load(load), .serial_data_out(sdo1), .cfg_update(upd1),
      .mgmt_gpio_out(mgmt_out), .mgmt_gpio_oeb(mgmt_oeb), .mgmt_gpio_in(m_in1),
      .user_gpio_out(user_out), .user_gpio_oeb(user_oeb), .user_gpio_in(u_in1),
      .pad_gpio_in(pad_in), .pad_gpio_out(p_out1), .pad_gpio_outenb(p_oeb1),
      .pad_gpio_inenb(inenb1), .pad_gpio_holdover(hold1), .pad_gpio_ib_mode_sel(ib1),
      .pad_gpio_vtrip_sel(vt1), .pad_gpio_slow_sel(sl1), .pad_gpio_ana_en(ae1),
      .pad_gpio_ana_sel(as1), .pad_gpio_ana_pol(ap1), .pad_gpio_dm(dm1)
   );

   gpio_ctrl_shift dut2 (
      .wb_clk_i(clk), .wb_rst_i(rst), .serial_data_in(sdo1), .serial_shift(shift),
      .serial_load(load), .serial_data_out(sdo2), .cfg_update(upd2),
      .mgmt_gpio_out(mgmt_out), .mgmt_gpio_oeb(mgmt_oeb), .mgmt_gpio_in(m_in2),
      .user_gpio_out(user_out), .user_gpio_oeb(user_oeb), .user_gpio_in(u_in2),
      .pad_gpio_in(pad_in), .pad_gpio_out(p_out2), .pad_gpio_outenb(p_oeb2),
      .pad_gpio_inenb(inenb2), .pad_gpio_holdover(hold2), .pad_gpio_ib_mode_sel(ib2),
      .pad_gpio_vtrip_sel(vt2), .pad_gpio_slow_sel(sl2), .pad_gpio_ana_en(ae2),
      .pad_gpio_ana_sel(as2), .pad_gpio_ana_pol(ap2), .pad_gpio_dm(dm2)
   );

   // Signal ids observable by the monitor
   localparam int unsigned ID_CFG1 = 0, ID_OUT1 = 1, ID_OEB1 = 2, ID_MIN1 = 3, ID_UIN1 = 4,
                           ID_SDO1 = 5, ID_UPD1 = 6, ID_CFG2 = 7, ID_SDO2 = 8, ID_OEB2 = 9,
                           ID_MIN2 = 10;

   typedef struct {
      string       name;
      int unsigned id;
      logic [15:0] val;
   } exp_t;

   exp_t        exp_q[$];
   logic [10:0] upd_q[$];
   int          asserts = 0;
   int          fails   = 0;
   bit          chk_pending = 0;

   // Observable cfg[12:2] rebuilt from the pad control outputs
   function automatic logic [15:0] observe(int unsigned id);
      case (id)
         ID_CFG1: return {5'd0, dm1, vt1, sl1, ap1, as1, ae1, ib1, inenb1, hold1};
         ID_OUT1: return {15'd0, p_out1};
         ID_OEB1: return {15'd0, p_oeb1};
         ID_MIN1: return {15'd0, m_in1};
         ID_UIN1: return {15'd0, u_in1};
         ID_SDO1: return {15'd0, sdo1};
         ID_UPD1: return {15'd0, upd1};
         ID_CFG2: return {5'd0, dm2, vt2, sl2, ap2, as2, ae2, ib2, inenb2, hold2};
         ID_SDO2: return {15'd0, sdo2};
         ID_OEB2: return {15'd0, p_oeb2};
         ID_MIN2: return {15'd0, m_in2};
         default: return 16'hDEAD;
      endcase
   endfunction

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [10:0] ue;
      logic [15:0] got;
      if (upd1 === 1'b1) begin
         asserts++;
         if (upd_q.size() == 0) begin
            fails++;
            $display("FAIL cfg_update_unexpected got=1 want=0 at %0t", $time);
         end else begin
            ue  = upd_q.pop_front();
            got = observe(ID_CFG1);
            if (got[10:0] !== ue) begin
               fails++;
               $display("FAIL cfg_after_update got=%0h want=%0h at %0t", got, ue, $time);
            end
         end
      end
      if (chk_pending) begin
         while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            got = observe(e.id);
            asserts++;
            if (got !== e.val) begin
               fails++;
               $display("FAIL %s got=%0h want=%0h at %0t", e.name, got, e.val, $time);
            end
         end
         chk_pending = 0;
      end
   end

   task automatic expect_sig(input string name, input int unsigned id, input logic [15:0] val);
      exp_t e;
      e.name = name; e.id = id; e.val = val;
      exp_q.push_back(e);
   endtask

   task automatic flush();
      chk_pending = 1;
      for (int i = 0; i < 30; i++) begin
         if (!chk_pending) break;
         #1;
      end
      if (chk_pending) begin
         asserts++;
         fails++;
         $display("FAIL monitor_timeout got=pending want=consumed");
         exp_q.delete();
         chk_pending = 0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic shift_word(input logic [12:0] w);
      for (int i = 12; i >= 0; i--) begin
         sdi = w[i]; shift = 1'b1;
         tick();
         shift = 1'b0;
      end
   endtask

   task automatic do_load(input logic [12:0] w);
      upd_q.push_back(w[12:2]);
      load = 1'b1;
      tick();
      load = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=running want=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; sdi = 1'b0; shift = 1'b0; load = 1'b0;
      mgmt_out = 1'b0; mgmt_oeb = 1'b0; user_out = 1'b0; user_oeb = 1'b1; pad_in = 1'b0;
      tick(); tick();
      rst = 1'b0;

      // Reset state
      expect_sig("rst_cfg", ID_CFG1, 16'h600);
      expect_sig("rst_outenb", ID_OEB1, 16'h1);
      expect_sig("rst_mgmt_in", ID_MIN1, 16'h0);
      expect_sig("rst_sdo", ID_SDO1, 16'h0);
      expect_sig("rst_cfg_update", ID_UPD1, 16'h0);
      flush();

      // Load 0x0402: user-owned pad, dm=001
      tick();
      shift_word(13'h0402);
      do_load(13'h0402);
      user_out = 1'b1; user_oeb = 1'b0;
      expect_sig("ld0402_cfg", ID_CFG1, 16'h100);
      expect_sig("ld0402_upd_high", ID_UPD1, 16'h1);
      expect_sig("ld0402_pad_out", ID_OUT1, 16'h1);
      expect_sig("ld0402_pad_oeb", ID_OEB1, 16'h0);
      flush();
      tick();
      expect_sig("ld0402_upd_low", ID_UPD1, 16'h0);
      flush();

      // Reset after 7 of 13 shifts, strobes held during reset
      for (int i = 0; i < 7; i++) begin
         sdi = 1'b1; shift = 1'b1;
         tick();
         shift = 1'b0;
      end
      #2 rst = 1'b1;
      expect_sig("midrst_cfg", ID_CFG1, 16'h600);
      expect_sig("midrst_sdo", ID_SDO1, 16'h0);
      flush();
      sdi = 1'b1; shift = 1'b1; load = 1'b1;
      tick(); tick();
      shift = 1'b0; load = 1'b0; sdi = 1'b0;
      rst = 1'b0;
      expect_sig("postrst_cfg", ID_CFG1, 16'h600);
      expect_sig("postrst_upd", ID_UPD1, 16'h0);
      flush();
      for (int i = 0; i < 12; i++) begin
         shift = 1'b1;
         tick();
         shift = 1'b0;
      end
      expect_sig("rst_strobes_ignored", ID_SDO1, 16'h0);
      flush();

      // Pad input latency (default mgmt-owned cfg, pad_in low so far)
      tick();
      pad_in = 1'b1;
`ifdef GPIO_CTRL_INPUT_SYNC_EN
      expect_sig("sync_edge0", ID_MIN1, 16'h0);
      flush();
      tick();
      expect_sig("sync_edge1", ID_MIN1, 16'h0);
      flush();
      tick();
      expect_sig("sync_edge2", ID_MIN1, 16'h1);
      flush();
`else
      expect_sig("comb_in", ID_MIN1, 16'h1);
      expect_sig("comb_user_in", ID_UIN1, 16'h0);
      flush();
`endif

      // Output-enable forcing and input gating
      tick(); tick();
      mgmt_oeb = 1'b0; mgmt_out = 1'b1;
      expect_sig("dflt_oeb_forced", ID_OEB1, 16'h1);
      expect_sig("dflt_mgmt_in", ID_MIN1, 16'h1);
      flush();
      shift_word(13'h1801);
      do_load(13'h1801);
      expect_sig("oe_cfg_outenb0", ID_OEB1, 16'h0);
      expect_sig("oe_cfg_pad_out", ID_OUT1, 16'h1);
      flush();
      shift_word(13'h1809);
      do_load(13'h1809);
      expect_sig("inpdis_cfg", ID_CFG1, 16'h602);
      expect_sig("inpdis_mgmt_in", ID_MIN1, 16'h0);
      expect_sig("inpdis_user_in", ID_UIN1, 16'h0);
      flush();

      // Shift and load in the same cycle
      shift_word(13'h0AAA);
      expect_sig("pre_combo_sdo", ID_SDO1, 16'h0);
      flush();
      tick();
      upd_q.push_back(11'h2AA);
      sdi = 1'b0; shift = 1'b1; load = 1'b1;
      tick();
      shift = 1'b0; load = 1'b0;
      expect_sig("combo_cfg", ID_CFG1, 16'h2AA);
      expect_sig("combo_sdo", ID_SDO1, 16'h1);
      flush();
      do_load(13'h1554);
      expect_sig("combo_shiftreg", ID_CFG1, 16'h555);
      flush();

      // Two-pad chain
      do_reset();
      user_out = 1'b0;
      for (int n = 1; n <= 26; n++) begin
         sdi = (n <= 13) ? 1'b1 : 1'b0; shift = 1'b1;
         tick();
         shift = 1'b0;
         if (n == 12) begin expect_sig("chain_sdo1_12", ID_SDO1, 16'h0); flush(); end
         if (n == 13) begin expect_sig("chain_sdo1_13", ID_SDO1, 16'h1); flush(); end
         if (n == 25) begin expect_sig("chain_sdo2_25", ID_SDO2, 16'h0); flush(); end
         if (n == 26) begin expect_sig("chain_sdo2_26", ID_SDO2, 16'h1); flush(); end
      end
      do_load(13'h0000);
      user_out = 1'b1;
      expect_sig("chain_cfg1", ID_CFG1, 16'h000);
      expect_sig("chain_cfg2", ID_CFG2, 16'h7FF);
      expect_sig("chain_pad1_user_out", ID_OUT1, 16'h1);
      expect_sig("chain_pad2_oeb", ID_OEB2, 16'h1);
      expect_sig("chain_pad2_min", ID_MIN2, 16'h0);
      flush();

      tick(); tick(); tick();
      asserts++;
      if (upd_q.size() != 0) begin
         fails++;
         $display("FAIL cfg_update_missing got=%0d want=0 pending", upd_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
